// File: rtl/gate_chk_pkg.sv
// Shared types, constants and helpers for the gate response checker.
//   state_t   : checker FSM state encoding
//   MISR_POLY : feedback taps of the 16-bit response signature register
//   MISR_SEED : value the signature register starts from
//   sat_inc   : increment that sticks at a ceiling instead of wrapping
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Callers pass their counter zero-extended to 32 bits and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sig_misr16.sv
// 16-bit serial-input signature register compressing the DUT response stream.
// Ports:
//   clk, rst_n : clock and async active-low reset (resets to the seed)
//   clear      : reload the seed (wins over en)
//   en         : shift in din this cycle
//   din        : response bit
//   sig        : current signature
module sig_misr16
  import gate_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ {15'b0, din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for a small combinational gate DUT: compares each sampled
// DUT output against a truth table, counts vectors and mismatches, tracks
// input-space coverage and builds a response signature.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : clear results and begin checking (also restarts a run)
//   stop              : end a run early (ignored outside CHECK)
//   sample_valid      : stim/dut_out are valid this cycle
//   stim              : input vector applied to the DUT
//   dut_out           : DUT output for stim
//   busy / done       : in CHECK / in DONE
//   pass              : zero errors and full coverage, valid while done
//   err_count         : saturating mismatch count
//   vec_count         : saturating checked-sample count
//   first_err_valid   : a mismatch has been captured
//   first_err_vec     : stim of the first mismatch
//   signature         : MISR over the accepted dut_out stream
//
// state | meaning
// IDLE  | after reset, samples ignored
// CHECK | samples compared, counted and folded into the signature
// DONE  | run finished (coverage complete or stop), results held
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT = 4'b1110,
  parameter int                    CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [15:0]      signature
);

  localparam int               TT_SZ   = 1 << N_IN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [N_IN-1:0]    fev_q, fev_d;
  logic               fevv_q, fevv_d;
  logic [TT_SZ-1:0]   mask_q, mask_d;
  logic               pass_q, pass_d;
  logic               busy_q, done_q;

  logic               accept;
  logic               exp_bit;
  logic               mismatch;

  // A sample coinciding with start is dropped: the run it would belong to is being cleared.
  assign accept  = (state_q == CHECK) && sample_valid && !start;
  assign exp_bit = EXP_TT[stim];
  // Case inequality so an X/Z response is flagged rather than silently matching.
  assign mismatch = (dut_out !== exp_bit);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fevv_d  = fevv_q;
    mask_d  = mask_q;
    pass_d  = pass_q;

    if (start) begin
      state_d = CHECK;
      vec_d   = '0;
      err_d   = '0;
      fev_d   = '0;
      fevv_d  = 1'b0;
      mask_d  = '0;
      pass_d  = 1'b0;
    end else if (state_q == CHECK) begin
      if (accept) begin
        vec_d  = CNT_W'(sat_inc(32'(vec_q), 32'(CNT_MAX)));
        mask_d = mask_q | (TT_SZ'(1) << stim);
        if (mismatch) begin
          err_d = CNT_W'(sat_inc(32'(err_q), 32'(CNT_MAX)));
          if (!fevv_q) begin
            fev_d  = stim;
            fevv_d = 1'b1;
          end
        end
      end
      // The mask is cleared on entry, so it can only be full here right after
      // the completing sample; that sample is already folded into *_d.
      if (stop || (&mask_d)) begin
        state_d = DONE;
        pass_d  = (err_d == '0) && (&mask_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fev_q   <= '0;
      fevv_q  <= 1'b0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fevv_q  <= fevv_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d == CHECK);
      done_q  <= (state_d == DONE);
    end
  end

  sig_misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .en    (accept),
    .din   (dut_out),
    .sig   (signature)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign vec_count       = vec_q;
  assign first_err_valid = fevv_q;
  assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, sample_valid, dut_out;
  logic [1:0] stim;

  logic       busy, done, pass, fevv;
  logic [7:0] err_count, vec_count;
  logic [1:0] fev;
  logic [15:0] signature;

  logic       s_busy, s_done, s_pass, s_fevv;
  logic [1:0] s_err, s_vec, s_fev;
  logic [15:0] s_sig;

  int checks = 0;
  int passed = 0;
  logic [15:0] model_sig;
  logic [15:0] good_sig;
  logic [15:0] flip_sig;

  always #5 clk = ~clk;

  gate_response_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_valid(sample_valid), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count),
    .first_err_valid(fevv), .first_err_vec(fev), .signature(signature)
  );

  gate_response_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_valid(sample_valid), .stim(stim), .dut_out(dut_out),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .vec_count(s_vec),
    .first_err_valid(s_fevv), .first_err_vec(s_fev), .signature(s_sig)
  );

  function automatic logic [15:0] misr(input logic [15:0] s, input logic d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle with the given inputs; sampling happens 1 time unit after the edge.
  task automatic cyc(input logic st, input logic sp, input logic sv,
                     input logic [1:0] s, input logic o);
    start = st; stop = sp; sample_valid = sv; stim = s; dut_out = o;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic samp(input logic [1:0] s, input logic o, input logic sp);
    cyc(1'b0, sp, 1'b1, s, o);
    model_sig = misr(model_sig, o);
  endtask

  task automatic begin_run();
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    model_sig = 16'hFFFF;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    stim = 2'd0; dut_out = 1'b0; model_sig = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fevv", fevv, 0);
    chk("rst_err", err_count, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_fev", fev, 0);
    chk("rst_sig", signature, 16'hFFFF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // samples in IDLE and stop in IDLE are ignored
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("idle_vec", vec_count, 0);
    chk("idle_sig", signature, 16'hFFFF);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // good OR responses, full coverage
    begin_run();
    chk("t1_busy", busy, 1);
    chk("t1_sig0", signature, 16'hFFFF);
    samp(2'd0, 1'b0, 1'b0);
    samp(2'd1, 1'b1, 1'b0);
    samp(2'd2, 1'b1, 1'b0);
    chk("t1_done_early", done, 0);
    chk("t1_vec3", vec_count, 3);
    samp(2'd3, 1'b1, 1'b0);
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_vec", vec_count, 4);
    chk("t1_err", err_count, 0);
    chk("t1_pass", pass, 1);
    chk("t1_fevv", fevv, 0);
    chk("t1_sig", signature, model_sig);
    good_sig = model_sig;

    // samples and stop in DONE are ignored
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("done_vec", vec_count, 4);
    chk("done_err", err_count, 0);
    chk("done_sig", signature, good_sig);
    chk("done_hold", done, 1);

    // AND-behaving DUT
    begin_run();
    chk("t2_pass_clr", pass, 0);
    samp(2'd0, 1'b0, 1'b0);
    samp(2'd1, 1'b0, 1'b0);
    samp(2'd2, 1'b0, 1'b0);
    samp(2'd3, 1'b1, 1'b0);
    chk("t2_err", err_count, 2);
    chk("t2_fev", fev, 1);
    chk("t2_fevv", fevv, 1);
    chk("t2_pass", pass, 0);
    chk("t2_vec", vec_count, 4);
    chk("t2_done", done, 1);
    chk("t2_sig", signature, model_sig);

    // repeat of the good run gives the same signature
    begin_run();
    samp(2'd0, 1'b0, 1'b0);
    samp(2'd1, 1'b1, 1'b0);
    samp(2'd2, 1'b1, 1'b0);
    samp(2'd3, 1'b1, 1'b0);
    chk("t4_sig_repeat", signature, good_sig);

    // one flipped response changes the signature
    begin_run();
    samp(2'd0, 1'b0, 1'b0);
    samp(2'd1, 1'b1, 1'b0);
    samp(2'd2, 1'b0, 1'b0);
    samp(2'd3, 1'b1, 1'b0);
    flip_sig = model_sig;
    chk("t4_sig_flip", signature, flip_sig);
    checks++;
    assert (signature !== good_sig) passed++;
    else $error("FAIL t4_sig_differs: observed %0h required anything but %0h", signature, good_sig);

    // start with no samples
    begin_run();
    chk("t4_empty_sig", signature, 16'hFFFF);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("t4_empty_done", done, 1);
    chk("t4_empty_vec", vec_count, 0);
    chk("t4_empty_pass", pass, 0);

    // partial coverage, stop with the last sample
    begin_run();
    samp(2'd0, 1'b0, 1'b0);
    samp(2'd0, 1'b0, 1'b0);
    samp(2'd3, 1'b1, 1'b1);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_vec", vec_count, 3);
    chk("t3_err", err_count, 0);
    chk("t3_pass", pass, 0);
    chk("t3_sig", signature, model_sig);

    // restart inside CHECK discards results and the coinciding sample
    begin_run();
    samp(2'd0, 1'b1, 1'b0);
    chk("rs_err_pre", err_count, 1);
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("rs_vec", vec_count, 0);
    chk("rs_err", err_count, 0);
    chk("rs_fevv", fevv, 0);
    chk("rs_busy", busy, 1);
    chk("rs_sig", signature, 16'hFFFF);

    // saturation: always-wrong response on stim 0, stop with the 5th sample
    begin_run();
    samp(2'd0, 1'b1, 1'b0);
    samp(2'd0, 1'b1, 1'b0);
    samp(2'd0, 1'b1, 1'b0);
    samp(2'd0, 1'b1, 1'b0);
    samp(2'd0, 1'b1, 1'b1);
    chk("t5_sat_err", s_err, 3);
    chk("t5_sat_vec", s_vec, 3);
    chk("t5_sat_done", s_done, 1);
    chk("t5_err", err_count, 5);
    chk("t5_vec", vec_count, 5);
    chk("t5_fev", fev, 0);
    chk("t5_fevv", fevv, 1);
    chk("t5_pass", pass, 0);

    // start from DONE of a failed run
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("t6_err", err_count, 0);
    chk("t6_fevv", fevv, 0);
    chk("t6_busy", busy, 1);
    chk("t6_done", done, 0);

    // asynchronous reset mid-run
    samp(2'd1, 1'b1, 1'b0);
    samp(2'd2, 1'b0, 1'b0);
    chk("t6_vec_pre", vec_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_pass", pass, 0);
    chk("t6_rst_vec", vec_count, 0);
    chk("t6_rst_err", err_count, 0);
    chk("t6_rst_fevv", fevv, 0);
    chk("t6_rst_fev", fev, 0);
    chk("t6_rst_sig", signature, 16'hFFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_after", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
